// File: rtl/acc_stream_32bit.sv
// ---------------------------------------------------------------------------
// adder_32bit
//   Combinational 32-bit adder used as the accumulator datapath.
//   A, B : operands            S : A+B mod 2^32        C32 : carry out of bit 32
// ---------------------------------------------------------------------------
module adder_32bit (
  input  logic [32:1] A,
  input  logic [32:1] B,
  output logic [32:1] S,
  output logic        C32
);
  assign {C32, S} = {1'b0, A} + {1'b0, B};
endmodule

// ---------------------------------------------------------------------------
// acc_stream_32bit
//   Streaming multi-operand accumulator. Accepts a frame of 32-bit operands on
//   a valid/ready input, sums them modulo 2^32 through one adder_32bit, counts
//   carries out of bit 32 and operands (both saturating), and presents one
//   result per frame on a valid/ready output.
//
//   Ports
//     clk, rst      clock; asynchronous active-high reset
//     in_valid      operand present on in_data
//     in_ready      block can accept an operand this cycle
//     in_data       32-bit operand
//     in_last       in_data is the final operand of the frame
//     out_valid     frame result valid (HOLD state)
//     out_ready     consumer accepts the result
//     out_sum       frame sum mod 2^32
//     out_carries   number of carry-out events in the frame (saturating)
//     out_count     number of operands in the frame (saturating)
//     out_sat       a counter saturated during the frame (sticky)
//     dbg_state_o   current FSM state, for observation only
//
//   Handshake: a transfer happens on a rising clk edge where valid & ready are
//   both 1. A producer holding valid keeps its data stable until that edge;
//   ready never depends combinationally on valid on either side.
// ---------------------------------------------------------------------------
module acc_stream_32bit #(
  parameter int CW = 8,
  parameter int NW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [32:1]   in_data,
  input  logic          in_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [32:1]   out_sum,
  output logic [CW:1]   out_carries,
  output logic [NW:1]   out_count,
  output logic          out_sat,
  output logic [1:0]    dbg_state_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic [CW:1] CARRY_MAX = '1;
  localparam logic [NW:1] COUNT_MAX = '1;

  state_t        state_q;
  logic [32:1]   acc_q;
  logic [CW:1]   carries_q;
  logic [NW:1]   count_q;
  logic          sat_q;
  logic          out_valid_q;

  // Datapath and next-value signals
  logic [32:1]   add_a;
  logic [32:1]   add_s;
  logic          add_c32;
  logic          accept;
  logic [CW:1]   carries_d;
  logic [NW:1]   count_d;
  logic          sat_d;

  // A new frame starts from zero, so the A operand is only the running sum
  // while a frame is in progress.
  assign add_a = (state_q == ACCUM) ? acc_q : '0;

  adder_32bit u_adder (
    .A   (add_a),
    .B   (in_data),
    .S   (add_s),
    .C32 (add_c32)
  );

  // in_ready is gated by rst directly so it is 0 throughout reset and rises
  // as soon as reset releases, without waiting for a clock edge.
  assign in_ready = ~rst & (state_q != HOLD);
  assign accept   = in_valid & in_ready;

  // Saturating increments used while accumulating. Saturation is flagged when
  // an increment is requested on a counter already at all-ones.
  always_comb begin
    carries_d = carries_q;
    count_d   = count_q;
    sat_d     = sat_q;
    if (add_c32) begin
      if (carries_q == CARRY_MAX) sat_d = 1'b1;
      else                        carries_d = carries_q + CW'(1);
    end
    if (count_q == COUNT_MAX) sat_d = 1'b1;
    else                      count_d = count_q + NW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      carries_q   <= '0;
      count_q     <= '0;
      sat_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            acc_q     <= add_s;
            carries_q <= CW'(add_c32);
            count_q   <= NW'(1);
            sat_q     <= 1'b0;
            if (in_last) begin
              state_q     <= HOLD;
              out_valid_q <= 1'b1;
            end else begin
              state_q <= ACCUM;
            end
          end
        end
        ACCUM: begin
          if (accept) begin
            acc_q     <= add_s;
            carries_q <= carries_d;
            count_q   <= count_d;
            sat_q     <= sat_d;
            if (in_last) begin
              state_q     <= HOLD;
              out_valid_q <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            acc_q       <= '0;
            carries_q   <= '0;
            count_q     <= '0;
            sat_q       <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid   = out_valid_q;
  assign out_sum     = acc_q;
  assign out_carries = carries_q;
  assign out_count   = count_q;
  assign out_sat     = sat_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_acc_stream_32bit.sv
// ---------------------------------------------------------------------------
// tb_acc_stream_32bit
//   Directed bench for acc_stream_32bit. Inputs change on the falling edge,
//   the DUT samples on the rising edge, outputs are checked on the falling
//   edge. Expected frame sums are queued in exp_q when a frame is planned and
//   popped when its result appears.
// ---------------------------------------------------------------------------
module tb_acc_stream_32bit;

  localparam int CW = 8;
  localparam int NW = 16;

  // Clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          in_valid;
  logic          in_ready;
  logic [32:1]   in_data;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [32:1]   out_sum;
  logic [CW:1]   out_carries;
  logic [NW:1]   out_count;
  logic          out_sat;
  logic [1:0]    dbg_state;

  acc_stream_32bit #(.CW(CW), .NW(NW)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_last     (in_last),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_sum     (out_sum),
    .out_carries (out_carries),
    .out_count   (out_count),
    .out_sat     (out_sat),
    .dbg_state_o (dbg_state)
  );

  // Scoreboard
  logic [31:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Driver: present one operand and hold it until the edge that accepts it.
  task automatic send(input logic [31:0] d, input logic l);
    int guard;
    guard = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) chk("send_ready_timeout", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Result must be valid on the cycle right after the last accept; consume it
  // and confirm the block is back in IDLE with cleared registers.
  task automatic expect_result(input string tag, input logic [31:0] carries,
                               input logic [31:0] count, input logic sat);
    logic [31:0] exp_sum;
    exp_sum = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
    @(negedge clk);
    chk({tag, "_valid"},   {31'd0, out_valid}, 32'd1);
    chk({tag, "_sum"},     out_sum, exp_sum);
    chk({tag, "_carries"}, 32'(out_carries), carries);
    chk({tag, "_count"},   32'(out_count), count);
    chk({tag, "_sat"},     {31'd0, out_sat}, {31'd0, sat});
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk({tag, "_idle_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_idle_ready"}, {31'd0, in_ready}, 32'd1);
    chk({tag, "_idle_count"}, 32'(out_count), 32'd0);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;

    // Reset state
    #2;
    chk("rst_in_ready",  {31'd0, in_ready},  32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_sum",   out_sum, 32'd0);
    chk("rst_state",     {30'd0, dbg_state}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rel_in_ready", {31'd0, in_ready}, 32'd1);

    // T1: 1 + 2 + 3
    exp_q.push_back(32'd6);
    send(32'd1, 1'b0);
    send(32'd2, 1'b0);
    send(32'd3, 1'b1);
    expect_result("t1", 32'd0, 32'd3, 1'b0);

    // T2: wrap through bit 32
    exp_q.push_back(32'h0000_0001);
    send(32'hFFFF_FFFF, 1'b0);
    send(32'h0000_0002, 1'b1);
    expect_result("t2", 32'd1, 32'd2, 1'b0);

    // T3: 300 x all-ones; 299 carries saturate the 8-bit counter at 255
    exp_q.push_back(32'hFFFF_FED4);
    for (int i = 0; i < 300; i++) send(32'hFFFF_FFFF, (i == 299));
    expect_result("t3", 32'd255, 32'd300, 1'b1);

    // T4: result held under backpressure while an operand is offered
    send(32'd10, 1'b0);
    send(32'd20, 1'b1);
    in_valid = 1'b1;
    in_data  = 32'd99;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t4_hold_valid", {31'd0, out_valid}, 32'd1);
      chk("t4_hold_ready", {31'd0, in_ready}, 32'd0);
      chk("t4_hold_sum",   out_sum, 32'd30);
      chk("t4_hold_count", 32'(out_count), 32'd2);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk("t4_idle_valid", {31'd0, out_valid}, 32'd0);
    chk("t4_idle_state", {30'd0, dbg_state}, 32'd0);
    chk("t4_idle_count", 32'(out_count), 32'd0);

    // T5: reset mid-frame discards the partial frame
    send(32'd7, 1'b0);
    send(32'd8, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("t5_rst_sum",      out_sum, 32'd0);
    chk("t5_rst_count",    32'(out_count), 32'd0);
    chk("t5_rst_valid",    {31'd0, out_valid}, 32'd0);
    chk("t5_rst_in_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("t5_rel_in_ready", {31'd0, in_ready}, 32'd1);
    chk("t5_rel_valid",    {31'd0, out_valid}, 32'd0);
    exp_q.push_back(32'd5);
    send(32'd5, 1'b1);
    expect_result("t5", 32'd0, 32'd1, 1'b0);

    // T6: single-operand frame straight from IDLE
    exp_q.push_back(32'h8000_0000);
    send(32'h8000_0000, 1'b1);
    expect_result("t6", 32'd0, 32'd1, 1'b0);

    chk("exp_q_drained", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "timeout");
  end

endmodule
